// File: rtl/decode_execute_buffer_if.sv
// Decode-to-execute bus: hazard/flush controls, decoded operands in, registered copies out.
// The decode side uses the master modport, the pipeline register uses the slave modport.
interface decode_execute_buffer_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
);
  logic              load_use_enable;
  logic              pop_case;
  logic              flush;
  logic [DATA_W-1:0] pc_decode;
  logic [DATA_W-1:0] rs_data_decode;
  logic [DATA_W-1:0] rd_data_decode;
  logic [DATA_W-1:0] imm_decode;
  logic [REG_W-1:0]  rs_decode;
  logic [REG_W-1:0]  rd_decode;
  logic [3:0]        alu_op_decode;
  logic [CTRL_W-1:0] ctrl_decode;

  logic [DATA_W-1:0] pc_exec;
  logic [DATA_W-1:0] rs_data_exec;
  logic [DATA_W-1:0] rd_data_exec;
  logic [DATA_W-1:0] imm_exec;
  logic [REG_W-1:0]  rs_exec;
  logic [REG_W-1:0]  rd_exec;
  logic [3:0]        alu_op_exec;
  logic [CTRL_W-1:0] ctrl_exec;
  logic              valid_exec;
  logic [CNT_W-1:0]  bubble_count;
  logic              hazard_overrun;

  modport master (
    output load_use_enable, pop_case, flush,
    output pc_decode, rs_data_decode, rd_data_decode, imm_decode,
    output rs_decode, rd_decode, alu_op_decode, ctrl_decode,
    input  pc_exec, rs_data_exec, rd_data_exec, imm_exec,
    input  rs_exec, rd_exec, alu_op_exec, ctrl_exec, valid_exec,
    input  bubble_count, hazard_overrun
  );

  modport slave (
    input  load_use_enable, pop_case, flush,
    input  pc_decode, rs_data_decode, rd_data_decode, imm_decode,
    input  rs_decode, rd_decode, alu_op_decode, ctrl_decode,
    output pc_exec, rs_data_exec, rd_data_exec, imm_exec,
    output rs_exec, rd_exec, alu_op_exec, ctrl_exec, valid_exec,
    output bubble_count, hazard_overrun
  );
endinterface

// File: rtl/decode_execute_buffer.sv
// Decode/execute pipeline register with bounded stall bubbles, flush, a saturating
// bubble counter and a sticky flag for stall requests that outlive MAX_STALL.
module decode_execute_buffer #(
  parameter int DATA_W    = 16,
  parameter int REG_W     = 3,
  parameter int CTRL_W    = 10,
  parameter int MAX_STALL = 2,
  parameter int CNT_W     = 16
) (
  input logic                  clk,
  input logic                  rst,
  decode_execute_buffer_if.slave bus
);

  typedef enum logic [1:0] {RUN, STALL1, STALL2, OVER} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rd;
    logic [3:0]        alu_op;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } stage_t;

  state_e           state_q, state_d;
  stage_t           stage_q, stage_d, decode_in;
  logic [CNT_W-1:0] bubble_count_q, bubble_count_d;
  logic             hazard_overrun_q, hazard_overrun_d;
  logic             stall_req;
  logic             honour;
  logic             overrun;

  // Both hazard detectors are active-low: either one at 0 asks for a bubble.
  assign stall_req = ~bus.load_use_enable | ~bus.pop_case;

  assign decode_in = '{
    pc:      bus.pc_decode,
    rs_data: bus.rs_data_decode,
    rd_data: bus.rd_data_decode,
    imm:     bus.imm_decode,
    rs:      bus.rs_decode,
    rd:      bus.rd_decode,
    alu_op:  bus.alu_op_decode,
    ctrl:    bus.ctrl_decode,
    valid:   1'b1
  };

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    honour  = 1'b0;
    overrun = 1'b0;
    if (bus.flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (stall_req) begin
            honour  = 1'b1;
            state_d = STALL1;
          end
        end
        STALL1: begin
          if (!stall_req) begin
            state_d = RUN;
          end else if (MAX_STALL >= 2) begin
            honour  = 1'b1;
            state_d = STALL2;
          end else begin
            overrun = 1'b1;
            state_d = OVER;
          end
        end
        STALL2: begin
          if (stall_req) begin
            overrun = 1'b1;
            state_d = OVER;
          end else begin
            state_d = RUN;
          end
        end
        OVER: begin
          if (!stall_req) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stage_d          = stage_q;
    bubble_count_d   = bubble_count_q;
    hazard_overrun_d = hazard_overrun_q | overrun;
    if (bus.flush) begin
      stage_d.ctrl   = '0;
      stage_d.alu_op = '0;
      stage_d.valid  = 1'b0;
      stage_d.rd     = '0;
    end else if (honour) begin
      // Bubble keeps operands and PC; only the control side is squashed.
      stage_d.ctrl   = '0;
      stage_d.alu_op = '0;
      stage_d.valid  = 1'b0;
      if (bubble_count_q != '1) bubble_count_d = bubble_count_q + CNT_W'(1);
    end else begin
      stage_d = decode_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= RUN;
      stage_q          <= '0;
      bubble_count_q   <= '0;
      hazard_overrun_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      stage_q          <= stage_d;
      bubble_count_q   <= bubble_count_d;
      hazard_overrun_q <= hazard_overrun_d;
    end
  end

  assign bus.pc_exec        = stage_q.pc;
  assign bus.rs_data_exec   = stage_q.rs_data;
  assign bus.rd_data_exec   = stage_q.rd_data;
  assign bus.imm_exec       = stage_q.imm;
  assign bus.rs_exec        = stage_q.rs;
  assign bus.rd_exec        = stage_q.rd;
  assign bus.alu_op_exec    = stage_q.alu_op;
  assign bus.ctrl_exec      = stage_q.ctrl;
  assign bus.valid_exec     = stage_q.valid;
  assign bus.bubble_count   = bubble_count_q;
  assign bus.hazard_overrun = hazard_overrun_q;

endmodule

// File: tb/tb_decode_execute_buffer.sv
// Scoreboard bench for decode_execute_buffer: expected outputs are queued as stimulus is
// driven and compared one edge later; a second instance with an 8-bit counter exercises saturation.
module tb_decode_execute_buffer;

  localparam int MAX_STALL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_execute_buffer_if #(.CNT_W(16)) bus ();
  decode_execute_buffer_if #(.CNT_W(8))  bus_s ();

  decode_execute_buffer u_dut (.clk(clk), .rst(rst), .bus(bus));
  decode_execute_buffer #(.CNT_W(8)) u_sat (.clk(clk), .rst(rst), .bus(bus_s));

  typedef struct {
    logic [15:0] pc, rs_data, rd_data, imm;
    logic [2:0]  rs, rd;
    logic [3:0]  alu;
    logic [9:0]  ctrl;
    logic        valid;
    logic [15:0] bcnt;
    logic        ovr;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;
  int   consec;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m      = '{default: '0};
    consec = 0;
    sb_q.delete();
  endtask

  task automatic rand_decode();
    bus.pc_decode      = 16'($urandom);
    bus.rs_data_decode = 16'($urandom);
    bus.rd_data_decode = 16'($urandom);
    bus.imm_decode     = 16'($urandom);
    bus.rs_decode      = 3'($urandom);
    bus.rd_decode      = 3'($urandom);
    bus.alu_op_decode  = 4'($urandom);
    bus.ctrl_decode    = 10'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"},    bus.pc_exec, 0);
    check({tag, "_rsd"},   bus.rs_data_exec, 0);
    check({tag, "_rdd"},   bus.rd_data_exec, 0);
    check({tag, "_imm"},   bus.imm_exec, 0);
    check({tag, "_rs"},    bus.rs_exec, 0);
    check({tag, "_rd"},    bus.rd_exec, 0);
    check({tag, "_alu"},   bus.alu_op_exec, 0);
    check({tag, "_ctrl"},  bus.ctrl_exec, 0);
    check({tag, "_valid"}, bus.valid_exec, 0);
    check({tag, "_bcnt"},  bus.bubble_count, 0);
    check({tag, "_ovr"},   bus.hazard_overrun, 0);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check("pc_exec",        bus.pc_exec, e.pc);
    check("rs_data_exec",   bus.rs_data_exec, e.rs_data);
    check("rd_data_exec",   bus.rd_data_exec, e.rd_data);
    check("imm_exec",       bus.imm_exec, e.imm);
    check("rs_exec",        bus.rs_exec, e.rs);
    check("rd_exec",        bus.rd_exec, e.rd);
    check("alu_op_exec",    bus.alu_op_exec, e.alu);
    check("ctrl_exec",      bus.ctrl_exec, e.ctrl);
    check("valid_exec",     bus.valid_exec, e.valid);
    check("bubble_count",   bus.bubble_count, e.bcnt);
    check("hazard_overrun", bus.hazard_overrun, e.ovr);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic lu, input logic pk, input logic fl, input bit rnd);
    bit stall;
    if (rnd) rand_decode();
    bus.load_use_enable = lu;
    bus.pop_case        = pk;
    bus.flush           = fl;
    stall = !lu || !pk;
    if (fl) begin
      m.ctrl = '0; m.alu = '0; m.valid = 1'b0; m.rd = '0;
      consec = 0;
    end else if (stall && consec < MAX_STALL) begin
      m.ctrl = '0; m.alu = '0; m.valid = 1'b0;
      if (m.bcnt != 16'hFFFF) m.bcnt = m.bcnt + 16'd1;
      consec++;
    end else begin
      if (stall) begin
        m.ovr = 1'b1;
        consec++;
      end else begin
        consec = 0;
      end
      m.pc = bus.pc_decode; m.rs_data = bus.rs_data_decode; m.rd_data = bus.rd_data_decode;
      m.imm = bus.imm_decode; m.rs = bus.rs_decode; m.rd = bus.rd_decode;
      m.alu = bus.alu_op_decode; m.ctrl = bus.ctrl_decode; m.valid = 1'b1;
    end
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    compare_out();
    @(negedge clk);
  endtask

  int exp_cnt;

  task automatic sat_cycle(input logic lu);
    bus_s.load_use_enable = lu;
    @(posedge clk);
    #1;
    if (!lu && exp_cnt != 255) exp_cnt++;
    @(negedge clk);
  endtask

  initial begin
    bus.load_use_enable = 1'b1; bus.pop_case = 1'b1; bus.flush = 1'b0;
    bus.pc_decode = 16'hBEEF; bus.rs_data_decode = 16'h1111; bus.rd_data_decode = 16'h2222;
    bus.imm_decode = 16'h3333; bus.rs_decode = 3'd5; bus.rd_decode = 3'd6;
    bus.alu_op_decode = 4'hA; bus.ctrl_decode = 10'h3FF;
    bus_s.load_use_enable = 1'b1; bus_s.pop_case = 1'b1; bus_s.flush = 1'b0;
    bus_s.pc_decode = '0; bus_s.rs_data_decode = '0; bus_s.rd_data_decode = '0;
    bus_s.imm_decode = '0; bus_s.rs_decode = '0; bus_s.rd_decode = '0;
    bus_s.alu_op_decode = '0; bus_s.ctrl_decode = '0;

    // Asynchronous reset with nonzero inputs and no clock edge
    #2 rst = 1'b1;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    bus.pc_decode = 16'h0010; bus.ctrl_decode = 10'h001;
    cycle(1, 1, 0, 0);
    check("first_pc", bus.pc_exec, 16'h0010);
    check("first_valid", bus.valid_exec, 1);
    repeat (3) cycle(1, 1, 0, 1);

    // Load-use bubble holds operands
    rand_decode();
    bus.rd_data_decode = 16'h1234;
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 1);
    check("lu_hold_rd_data", bus.rd_data_exec, 16'h1234);
    check("lu_bcnt", bus.bubble_count, 1);
    cycle(1, 1, 0, 1);

    // Pop-jump: two honoured bubbles, then capture
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 1, 0, 1);
    check("pj_bcnt", bus.bubble_count, 3);
    check("pj_no_ovr", bus.hazard_overrun, 0);

    // Overrun: four stall edges, last two capture
    repeat (4) cycle(0, 1, 0, 1);
    check("ovr_valid", bus.valid_exec, 1);
    repeat (2) cycle(1, 1, 0, 1);
    check("ovr_sticky", bus.hazard_overrun, 1);

    // Back-to-back single-cycle stalls
    repeat (2) begin
      cycle(0, 1, 0, 1);
      cycle(1, 1, 0, 1);
    end

    // Flush beats a concurrent stall, also from inside a stall
    cycle(1, 0, 1, 1);
    cycle(0, 1, 0, 1);
    cycle(0, 0, 1, 1);
    repeat (3) cycle(1, 0, 0, 1);

    // Reset in the middle of a stall
    cycle(0, 1, 0, 1);
    rst = 1'b1;
    #1 check_all_zero("rst_mid");
    @(posedge clk);
    #1 check_all_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) cycle(0, 1, 0, 1);
    cycle(1, 1, 0, 1);

    // Random soak
    repeat (60) cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
                      logic'($urandom_range(0, 9) == 0), 1);

    // Saturation on the 8-bit counter instance
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    repeat (127) begin
      sat_cycle(0);
      sat_cycle(0);
      sat_cycle(1);
    end
    check("sat_preload", bus_s.bubble_count, exp_cnt);
    check("sat_preload_fe", bus_s.bubble_count, 8'hFE);
    sat_cycle(0);
    check("sat_reach", bus_s.bubble_count, 8'hFF);
    sat_cycle(0);
    check("sat_hold1", bus_s.bubble_count, 8'hFF);
    sat_cycle(1);
    sat_cycle(0);
    check("sat_hold2", bus_s.bubble_count, 8'hFF);
    check("sat_model", bus_s.bubble_count, exp_cnt);
    check("sat_no_ovr", bus_s.hazard_overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_execute_buffer.md
# decode_execute_buffer

Pipeline register between the decode and execute stages. It captures decoded operands, register addresses and control bits on each rising clock edge. It inserts a NOP bubble when either decode-stage hazard detector requests a stall, and zeroes its contents on a control-flow flush. A small stall-tracking FSM bounds consecutive bubbles and flags hazard-unit misbehaviour.

## Interface
Parameters:
- DATA_W, 16, operand/immediate/PC width
- REG_W, 3, register-address width
- CTRL_W, 10, control-bundle width. Bit map: [0] regWrite, [1] memRead, [2] memWrite, [3] pop, [4] push, [5] jmp, [6] out, [7] in, [8] imm_en, [9] setc
- MAX_STALL, 2, maximum consecutive bubbles honoured

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- load_use_enable  in  1  load-use/pop hazard detector output; 0 = insert bubble
- pop_case  in  1  pop-jump hazard detector output; 0 = insert bubble
- flush  in  1  taken branch/jump resolved in execute; discard decode contents
- pc_decode  in  DATA_W  PC of decode instruction
- rs_data_decode, rd_data_decode, imm_decode  in  DATA_W each  operands
- rs_decode, rd_decode  in  REG_W each  source/destination addresses
- alu_op_decode  in  4  ALU opcode
- ctrl_decode  in  CTRL_W  control bundle
- pc_exec, rs_data_exec, rd_data_exec, imm_exec  out  DATA_W  registered copies
- rs_exec, rd_exec  out  REG_W  registered addresses
- alu_op_exec  out  4  registered opcode
- ctrl_exec  out  CTRL_W  registered control bundle
- valid_exec  out  1  1 = execute holds a real instruction
- bubble_count  out  16  bubbles inserted since reset, saturating
- hazard_overrun  out  1  sticky: a stall request exceeded MAX_STALL

## Operation
- stall_req = ~load_use_enable | ~pop_case, sampled at the rising edge.
- Per-edge priority: rst > flush > honoured stall > capture.
- Capture: all *_exec outputs take the *_decode values; valid_exec=1.
- Bubble (honoured stall): ctrl_exec=0, alu_op_exec=0, valid_exec=0. Data, address and PC outputs hold their previous values. bubble_count increments unless it is at 0xFFFF.
- Flush: identical to bubble for ctrl_exec, alu_op_exec and valid_exec, and rd_exec is also cleared to 0. bubble_count does not increment. FSM returns to RUN.
- Stall FSM states, with transitions at the edge:
  - RUN: stall_req -> STALL1 (bubble); otherwise stay (capture).
  - STALL1: stall_req and MAX_STALL≥2 -> STALL2 (bubble); stall_req and MAX_STALL=1 -> OVER; no request -> RUN (capture).
  - STALL2: stall_req -> OVER (request ignored, capture performed, hazard_overrun set); no request -> RUN (capture).
  - OVER: stall_req -> stay (capture, request ignored); no request -> RUN (capture).
- hazard_overrun clears only on rst.
- flush in any state forces RUN.
- Flush is not blocked by a concurrent stall request; that stall request is dropped.

## Timing
- Latency: 1 cycle from decode inputs to *_exec outputs.
- Reset, asynchronous, takes effect immediately without waiting for a clock edge:
  - all *_exec outputs = 0, valid_exec=0, bubble_count=0, hazard_overrun=0, FSM=RUN.
  - Reset asserted mid-stall abandons the stall; the first edge after release behaves as RUN.
- Stall inputs are level signals; the decode stage and PC freeze on the same level. This block does not re-register them.
- bubble_count saturates at 0xFFFF and never wraps.
- Two back-to-back single-cycle stalls separated by one capture cycle are legal: RUN->STALL1->RUN->STALL1.

## Test plan
- Reset: assert rst with nonzero inputs and no clock -> all outputs 0 at once. Release, drive pc_decode=0x0010, ctrl=0x001 -> next edge pc_exec=0x0010, ctrl_exec=0x001, valid_exec=1.
- Load-use bubble: load_use_enable=0 for one edge with rd_data_exec=0x1234 held -> ctrl_exec=0, valid_exec=0, rd_data_exec stays 0x1234, bubble_count=1. The next edge captures the new instruction.
- Pop-jump two bubbles: pop_case=0 for two edges -> two bubbles, bubble_count=2, FSM passes STALL1 then STALL2 then RUN, hazard_overrun=0.
- Overrun: load_use_enable=0 for four edges -> bubbles on edges 1-2. Edges 3-4 capture decode values with valid_exec=1. hazard_overrun=1 and remains 1 after stall_req drops.
- Flush vs stall: flush=1 and pop_case=0 on the same edge -> ctrl_exec=0, rd_exec=0, valid_exec=0, bubble_count unchanged, FSM=RUN.
- Saturation: preload 0xFFFE bubbles by running 65534 single-cycle stalls, then apply three more -> bubble_count=0xFFFF and held.
